// File: rtl/serial_nibble_add_ctrl_pkg.sv
// Shared definitions for the serial nibble add/subtract sequencer.
package serial_nibble_add_ctrl_pkg;

  // Width of the shared adder slice.
  localparam int unsigned NIBBLE_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_adder4.sv
// Combinational 4-bit ripple-carry adder slice.
module nibble_adder4
  import serial_nibble_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c0,
  output logic [NIBBLE_W-1:0] f,
  output logic                c4
);

  logic [NIBBLE_W:0] c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    c    = '0;
    f    = '0;
    c[0] = c0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      f[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign c4 = c[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_add_ctrl.sv
// Sequencer performing a W-bit add/subtract one nibble per clock through a
// single shared 4-bit adder slice, LSB nibble first, with a registered carry.
module serial_nibble_add_ctrl
  import serial_nibble_add_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e                           state_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] b_q;     // effective B (already inverted for sub)
  logic [NIBBLES-1:0][NIBBLE_W-1:0] work_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] work_d;
  logic                             carry_q;
  logic                             a_msb_q;
  logic                             b_msb_q;
  logic [IdxW-1:0]                  idx_q;
  logic                             busy_q;
  logic                             done_q;
  logic [W-1:0]                     sum_q;
  logic                             cout_q;
  logic                             ovf_q;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_f;
  logic                slice_c4;

  // Select the current nibble pair and merge the slice result into the work word.
  always_comb begin
    slice_a         = a_q[idx_q];
    slice_b         = b_q[idx_q];
    work_d          = work_q;
    work_d[idx_q]   = slice_f;
  end

  nibble_adder4 u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .c0 (carry_q),
    .f  (slice_f),
    .c4 (slice_c4)
  );

  // Sequencer state, operand capture, carry chain and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b ^ {W{op_sub}};
            // Subtract is a + ~b + 1, so the incoming carry is forced high.
            carry_q <= op_sub | cin;
            a_msb_q <= a[W-1];
            b_msb_q <= b[W-1] ^ op_sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          work_q  <= work_d;
          carry_q <= slice_c4;
          if (idx_q == LastIdx) begin
            sum_q   <= work_d;
            cout_q  <= slice_c4;
            ovf_q   <= (a_msb_q == b_msb_q) && (work_d[NIBBLES-1][NIBBLE_W-1] != a_msb_q);
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// Self-checking bench for serial_nibble_add_ctrl (NIBBLES=4, W=16).
module tb_serial_nibble_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int total;
  int bad;

  serial_nibble_add_ctrl #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mcin,
                                input logic msub, output logic [15:0] ms, output logic mc,
                                output logic mo);
    int u;
    int sv;
    if (!msub) begin
      u  = int'(ma) + int'(mb) + int'(mcin);
      sv = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
      mc = (u > 65535);
    end else begin
      u  = int'(ma) - int'(mb);
      sv = int'($signed(ma)) - int'($signed(mb));
      mc = (ma >= mb);
    end
    ms = u[15:0];
    mo = (sv > 32767) || (sv < -32768);
  endfunction

  // Issue one operation from a negedge; returns observations at the negedge where done is seen.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                        input logic isub, input bit keep_start, input int poke_cyc,
                        output logic [15:0] osum, output logic ocout, output logic oovf,
                        output int lat, output int busy_cnt, output bit busy_at_done,
                        output bit sum_stable);
    logic [15:0] sum0;
    a = ia; b = ib; cin = icin; op_sub = isub; start = 1'b1;
    sum0 = sum;
    lat = -1; busy_cnt = 0; busy_at_done = 1'b0; sum_stable = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) begin
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); op_sub = 1'($urandom);
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        busy_at_done = busy;
        break;
      end
      if (busy) busy_cnt++;
      if (sum !== sum0) sum_stable = 1'b0;
      if (poke_cyc != 0 && n == poke_cyc) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      end else if (poke_cyc != 0 && n == poke_cyc + 1) begin
        start = 1'b0;
      end
    end
    osum = sum; ocout = cout; oovf = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if ({sum, cout, ovf} !== 18'h0) begin
      bad++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b exp=0", sum, cout, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  task automatic test_directed();
    vec_t v[5];
    logic [15:0] gs; logic gc, go; int lat, bc; bit bd, st;
    v[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[1] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].a, v[i].b, v[i].cin, v[i].sub, 1'b0, 0, gs, gc, go, lat, bc, bd, st);
      total++; if ({gs, gc, go} !== {v[i].s, v[i].c, v[i].o}) begin
        bad++; $display("FAIL directed%0d got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                        i, gs, gc, go, v[i].s, v[i].c, v[i].o);
      end
      total++; if (lat !== 5) begin bad++; $display("FAIL directed%0d_latency got=%0d exp=5", i, lat); end
      total++; if (bc !== 4 || bd !== 1'b0) begin
        bad++; $display("FAIL directed%0d_busy got cycles=%0d at_done=%b exp 4,0", i, bc, bd);
      end
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL directed%0d_idle got done=%b busy=%b exp 0,0", i, done, busy);
      end
    end
  endtask

  task automatic test_start_in_run();
    logic [15:0] gs; logic gc, go; int lat, bc; bit bd, st; int extra;
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 2, gs, gc, go, lat, bc, bd, st);
    total++; if ({gs, gc, go} !== {16'h5556, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ignore_start_result got sum=%h cout=%b ovf=%b exp 5556,0,0", gs, gc, go);
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL ignore_start_latency got=%0d exp=5", lat); end
    extra = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ignore_start_queued got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] gs; logic gc, go; int lat, bc; bit bd, st;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 0, gs, gc, go, lat, bc, bd, st);
    total++; if ({gs, gc, go, lat, bc, bd} !== {16'h5555, 1'b0, 1'b0, 32'd5, 32'd4, 1'b0}) begin
      bad++; $display("FAIL b2b_first got sum=%h cout=%b ovf=%b lat=%0d busy=%0d/%b exp 5555,0,0,5,4,0",
                      gs, gc, go, lat, bc, bd);
    end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 0, gs, gc, go, lat, bc, bd, st);
    total++; if ({gs, gc, go, lat, bc, bd} !== {16'h7FFF, 1'b1, 1'b1, 32'd5, 32'd4, 1'b0}) begin
      bad++; $display("FAIL b2b_second got sum=%h cout=%b ovf=%b lat=%0d busy=%0d/%b exp 7fff,1,1,5,4,0",
                      gs, gc, go, lat, bc, bd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] gs; logic gc, go; int lat, bc; bit bd, st; int seen;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, gs, gc, go, lat, bc, bd, st);
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b1; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      bad++; $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                      busy, done, sum, cout, ovf);
    end
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrun_no_done got=%0d exp=0", seen); end
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, gs, gc, go, lat, bc, bd, st);
    total++; if ({gs, gc, go, lat} !== {16'h8000, 1'b0, 1'b1, 32'd5}) begin
      bad++; $display("FAIL midrun_next got sum=%h cout=%b ovf=%b lat=%0d exp 8000,0,1,5",
                      gs, gc, go, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, gs, es; logic rc, rs, gc, go, ec, eo; int lat, bc; bit bd, st, keep;
    keep = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!keep) @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) ra = 16'h8000;
      keep = ($urandom_range(0, 3) == 0) && (i != 39);
      model(ra, rb, rc, rs, es, ec, eo);
      run_op(ra, rb, rc, rs, keep, 0, gs, gc, go, lat, bc, bd, st);
      total++; if ({gs, gc, go} !== {es, ec, eo}) begin
        bad++; $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got %h/%b/%b exp %h/%b/%b",
                        i, ra, rb, rc, rs, gs, gc, go, es, ec, eo);
      end
      total++; if (lat !== 5 || bc !== 4 || bd !== 1'b0) begin
        bad++; $display("FAIL rand%0d_timing got lat=%0d busy=%0d/%b exp 5,4,0", i, lat, bc, bd);
      end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL rand%0d_sum_stable got=%b exp=1", i, st); end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
